// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: stalls the core around a req/ack memory access,
// steers byte lanes for sub-word loads/stores and flags misalignment and bus timeouts.
module dmem_access_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [31:0]       Addr,
   input  logic [DATA_W-1:0] WrData,
   output logic [DATA_W-1:0] RdData,
   output logic              Stall,
   output logic              MisalignErr,
   output logic              BusErr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          lane_q, lane_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rd_q, rd_d;
   logic                stall, misalign, acc, misaligned;
   logic                unused_addr;

   assign unused_addr = ^Addr[31:ADDR_W+2];

   function automatic logic is_byte(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b100);
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return (f3 == 3'b001) || (f3 == 3'b101);
   endfunction

   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic wr);
      if (!wr)              return 4'b1111;
      else if (is_byte(f3)) return 4'b0001 << lane;
      else if (is_half(f3)) return 4'b0011 << {lane[1], 1'b0};
      else                  return 4'b1111;
   endfunction

   function automatic logic [DATA_W-1:0] lane_wdata(input logic [2:0] f3,
                                                    input logic [DATA_W-1:0] wd);
      if (is_byte(f3))      return {4{wd[7:0]}};
      else if (is_half(f3)) return {2{wd[15:0]}};
      else                  return wd;
   endfunction

   // Undefined load encodings fall through to a full-word result.
   function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [DATA_W-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   assign acc        = MemRead | MemWrite;
   assign misaligned = is_half(Funct3) ? Addr[0] :
                       is_byte(Funct3) ? 1'b0 : (Addr[1:0] != 2'b00);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      lane_d   = lane_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      stall    = 1'b0;
      misalign = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (acc && misaligned) begin
               misalign = 1'b1;
            end else if (acc) begin
               addr_d   = Addr[ADDR_W+1:2];
               we_d     = MemWrite;
               be_d     = lane_be(Funct3, Addr[1:0], MemWrite);
               wdata_d  = lane_wdata(Funct3, WrData);
               funct3_d = Funct3;
               lane_d   = Addr[1:0];
               cnt_d    = '0;
               stall    = 1'b1;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            stall = 1'b1;
            // An ack on the final permitted cycle still completes the access.
            if (mem_ack) begin
               if (!we_q) rd_d = load_ext(funct3_q, lane_q, mem_rdata);
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               rd_d    = '0;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         lane_q   <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         lane_q   <= lane_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
      end
   end

   assign Stall       = stall & ~reset;
   assign MisalignErr = misalign & ~reset;
   assign BusErr      = (state_q == S_ERR);
   assign mem_req     = (state_q == S_REQ);
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_be      = be_q;
   assign mem_wdata   = wdata_q;
   assign RdData      = rd_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads, stores, misalignment, timeout and reset.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] Addr, WrData, RdData;
   logic        Stall, MisalignErr, BusErr;
   logic        mem_req, mem_we, mem_ack;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;

   // Observations collected by run_access
   int          stall_cnt, req_cnt;
   logic        fin, misal_seen, bus_seen, stall_after, unstable;
   logic [31:0] done_rd, cap_wdata;
   logic [8:0]  cap_addr;
   logic [3:0]  cap_be;
   logic        cap_we;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
      .Stall(Stall), .MisalignErr(MisalignErr), .BusErr(BusErr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // Drives one instruction and plays the memory; ack_delay = REQ cycle of ack (0 = never).
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_delay, input logic [31:0] rdata);
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
      #1;
      stall_cnt = Stall ? 1 : 0;
      misal_seen = MisalignErr;
      req_cnt = 0; fin = 1'b0; bus_seen = 1'b0; stall_after = 1'b1; unstable = 1'b0;
      done_rd = 32'hx;
      for (int i = 0; i < 40 && !fin; i++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (mem_req) begin
            if (req_cnt == 0) begin
               cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
            end else if (cap_addr !== mem_addr || cap_be !== mem_be ||
                         cap_wdata !== mem_wdata || cap_we !== mem_we) begin
               unstable = 1'b1;
            end
            req_cnt++;
            if (Stall) stall_cnt++;
            if (req_cnt == ack_delay) begin
               mem_ack = 1'b1; mem_rdata = rdata;
            end
         end else begin
            fin = 1'b1;
            done_rd = RdData; bus_seen = BusErr; stall_after = Stall;
         end
      end
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h10;
      WrData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      #12;
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", Stall); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req); end
      checks++; if (RdData !== 32'h0) begin errors++; $display("FAIL rst_rd got %h exp 0", RdData); end
      checks++; if (MisalignErr !== 1'b0 || BusErr !== 1'b0) begin errors++;
         $display("FAIL rst_err got %b%b exp 00", MisalignErr, BusErr); end
      checks++; if (mem_be !== 4'h0 || mem_we !== 1'b0) begin errors++;
         $display("FAIL rst_be got %h/%b exp 0/0", mem_be, mem_we); end
      @(posedge clk); #1;
      reset = 1'b0; MemRead = 1'b0;
   endtask

   task automatic test_lw();
      run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF);
      checks++; if (stall_cnt != 3) begin errors++; $display("FAIL lw_stall got %0d exp 3", stall_cnt); end
      checks++; if (done_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rd got %h exp deadbeef", done_rd); end
      checks++; if (cap_addr !== 9'd4) begin errors++; $display("FAIL lw_addr got %0d exp 4", cap_addr); end
      checks++; if (cap_be !== 4'b1111 || cap_we !== 1'b0) begin errors++;
         $display("FAIL lw_be got %b/%b exp 1111/0", cap_be, cap_we); end
      checks++; if (req_cnt != 2) begin errors++; $display("FAIL lw_req got %0d exp 2", req_cnt); end
      checks++; if (stall_after !== 1'b0) begin errors++; $display("FAIL lw_done_stall got %b exp 0", stall_after); end
      checks++; if (unstable) begin errors++; $display("FAIL lw_stable got unstable exp stable"); end
      @(posedge clk); #1;
      checks++; if (RdData !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hold got %h exp deadbeef", RdData); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b011};
      logic [31:0] ad [5]  = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
      logic [31:0] ex [5]  = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h80FF0000};
      for (int i = 0; i < 5; i++) begin
         run_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, 1, 32'h80FF0000);
         checks++; if (done_rd !== ex[i]) begin errors++;
            $display("FAIL load%0d_rd got %h exp %h", i, done_rd, ex[i]); end
         checks++; if (cap_be !== 4'b1111 || stall_cnt != 2) begin errors++;
            $display("FAIL load%0d_be got %b/%0d exp 1111/2", i, cap_be, stall_cnt); end
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3 [3] = '{3'b001, 3'b000, 3'b010};
      logic [31:0] ad [3] = '{32'h06, 32'h05, 32'h08};
      logic [31:0] wd [3] = '{32'h1234ABCD, 32'hCAFE0077, 32'h89ABCDEF};
      logic [3:0]  eb [3] = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] ew [3] = '{32'hABCDABCD, 32'h77777777, 32'h89ABCDEF};
      logic [8:0]  ea [3] = '{9'd1, 9'd1, 9'd2};
      for (int i = 0; i < 3; i++) begin
         run_access(1'b1, 1'b1, f3[i], ad[i], wd[i], 3, 32'h0);
         checks++; if (cap_we !== 1'b1 || cap_be !== eb[i]) begin errors++;
            $display("FAIL st%0d_be got %b/%b exp 1/%b", i, cap_we, cap_be, eb[i]); end
         checks++; if (cap_wdata !== ew[i] || cap_addr !== ea[i]) begin errors++;
            $display("FAIL st%0d_data got %h@%0d exp %h@%0d", i, cap_wdata, cap_addr, ew[i], ea[i]); end
         checks++; if (unstable || stall_cnt != 4) begin errors++;
            $display("FAIL st%0d_hold got %b/%0d exp 0/4", i, unstable, stall_cnt); end
      end
   endtask

   task automatic test_misalign();
      logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b101};
      logic [31:0] ad [3] = '{32'h02, 32'h01, 32'h13};
      for (int i = 0; i < 3; i++) begin
         run_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, 1, 32'h0);
         checks++; if (misal_seen !== 1'b1 || stall_cnt != 0) begin errors++;
            $display("FAIL mis%0d got err=%b stall=%0d exp 1/0", i, misal_seen, stall_cnt); end
         checks++; if (req_cnt != 0) begin errors++; $display("FAIL mis%0d_req got %0d exp 0", i, req_cnt); end
      end
      run_access(1'b1, 1'b0, 3'b000, 32'h03, 32'h0, 1, 32'h0);
      checks++; if (misal_seen !== 1'b0 || req_cnt != 1) begin errors++;
         $display("FAIL lb_noerr got %b/%0d exp 0/1", misal_seen, req_cnt); end
   endtask

   task automatic test_timeout();
      run_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h0);
      checks++; if (!fin) begin errors++; $display("FAIL to_fin got hang exp finish"); end
      checks++; if (req_cnt != 16) begin errors++; $display("FAIL to_req got %0d exp 16", req_cnt); end
      checks++; if (bus_seen !== 1'b1 || stall_after !== 1'b0) begin errors++;
         $display("FAIL to_bus got %b/%b exp 1/0", bus_seen, stall_after); end
      checks++; if (done_rd !== 32'h0) begin errors++; $display("FAIL to_rd got %h exp 0", done_rd); end
      @(posedge clk); #1;
      checks++; if (BusErr !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", BusErr); end
      run_access(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 16, 32'h5A5A5A5A);
      checks++; if (bus_seen !== 1'b0 || done_rd !== 32'h5A5A5A5A) begin errors++;
         $display("FAIL ack_last got %b/%h exp 0/5a5a5a5a", bus_seen, done_rd); end
   endtask

   task automatic test_ack_ignored();
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || RdData !== 32'h5A5A5A5A) begin errors++;
         $display("FAIL ack_idle got %b/%h exp 0/5a5a5a5a", mem_req, RdData); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h30;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req got %b exp 1", mem_req); end
      #2 reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin errors++;
         $display("FAIL mid_rst got %b/%b exp 0/0", mem_req, Stall); end
      @(posedge clk); #1;
      reset = 1'b0; MemRead = 1'b0;
      run_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1, 32'h01234567);
      checks++; if (done_rd !== 32'h01234567 || stall_cnt != 2) begin errors++;
         $display("FAIL mid_lw got %h/%0d exp 01234567/2", done_rd, stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_loads();
      test_stores();
      test_misalign();
      test_timeout();
      test_ack_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
